divider_seq: RTL and testbench

- Iterative unsigned integer divider. It is the inverse-operation companion to the pipelined DSP multiplier in the custom-function datapath.
- Produces the quotient and remainder of two WIDTH-bit operands using a restoring, one-bit-per-cycle algorithm. No DSP primitive is used.
- Uses a ready/valid input handshake and a single-cycle output valid pulse. This is the same valid_out style the multiplier uses, so pipeline control can track both units uniformly.

---
 rtl/divider_seq.sv | 135 +++++++++++++
 tb/tb_divider_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// divider_seq: iterative unsigned divider, restoring algorithm, one quotient
// bit per clock. Operands are latched on a ready/valid accept. Results are
// presented with a single-cycle out_valid pulse WIDTH+1 cycles later and then
// held until the next completion.
module divider_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             div_by_zero
);

    // Counter wide enough to hold 0..WIDTH.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    // The divider only refuses new work while it is iterating.
    assign in_ready = (state_q != ST_BUSY);
    assign accept   = in_valid && in_ready;

    // One restoring step. The partial remainder always stays below the
    // divisor, so its top bit is normally clear. If it were ever set, the
    // shifted value would exceed any divisor, so the subtraction is taken.
    assign shifted   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, div_q};
    assign trial_ok  = rem_q[WIDTH] | ~trial[WIDTH];
    assign rem_step  = trial_ok ? trial : shifted;
    assign quo_step  = {quo_q[WIDTH-2:0], trial_ok};
    assign last_iter = (count_q == LAST_ITER);

    // Next-state logic: accept/load, iterate, and publish the result on the
    // final iteration so the outputs never show intermediate values.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        rem_d           = rem_q;
        quo_d           = quo_q;
        div_d           = div_q;
        out_valid_d     = 1'b0;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        div_by_zero_d   = div_by_zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    quo_d   = dividend;
                    div_d   = divisor;
                    rem_d   = '0;
                    count_d = '0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    state_d         = ST_DONE;
                    out_valid_d     = 1'b1;
                    out_quotient_d  = quo_step;
                    out_remainder_d = rem_step[WIDTH-1:0];
                    div_by_zero_d   = (div_q == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            div_q           <= '0;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            div_by_zero_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            rem_q           <= rem_d;
            quo_q           <= quo_d;
            div_q           <= div_d;
            out_valid_q     <= out_valid_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            div_by_zero_q   <= div_by_zero_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign div_by_zero   = div_by_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: scoreboard bench for divider_seq (WIDTH=16). The stimulus
// process queues the expected result at each accept. An independent monitor
// pops an entry on every out_valid pulse and checks the data and the latency.
module tb_divider_seq;

    localparam int W = 16;
    localparam int LATENCY = W + 1;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend      (dividend),
        .divisor       (divisor),
        .out_valid     (out_valid),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .div_by_zero   (div_by_zero)
    );

    // Free-running clock and a cycle counter used to time latencies.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: plain integer division. Dividing by zero gives all ones and
    // returns the dividend as the remainder.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        e.acc = acc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Wait for in_ready, present one operation and queue its expected result.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, output int acc);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
            acc = -1;
        end else begin
            in_valid = 1'b1;
            dividend = a;
            divisor  = b;
            acc      = cyc;
            expQ.push_back(refModel(a, b, cyc));
            @(posedge clock);
            #1;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    // Wait for every queued result to come out, with a bounded budget.
    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checkOutput(name, expQ.size(), 0);
    endtask

    // Monitor: every out_valid pulse must match the oldest queued result.
    initial begin
        forever begin
            @(negedge clock);
            if (out_valid) begin
                pulses++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out_valid: got pulse with q=0x%0h, required none", out_quotient);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("quotient", 32'(out_quotient), 32'(monEntry.q));
                    checkOutput("remainder", 32'(out_remainder), 32'(monEntry.r));
                    checkOutput("div_by_zero", 32'(div_by_zero), 32'(monEntry.dbz));
                    checkOutput("latency", cyc - monEntry.acc, LATENCY);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int acc1;
        int acc2;
        int bad;
        int p0;
        int nOps;
        logic [W-1:0] bndA [4];
        logic [W-1:0] bndB [4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit hold;

        // Reset state while reset_n is low.
        #3;
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_quotient", 32'(out_quotient), 0);
        checkOutput("rst_remainder", 32'(out_remainder), 0);
        checkOutput("rst_div_by_zero", 32'(div_by_zero), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Basic divide: in_ready low for the whole iteration, then outputs held.
        $display("[TB] basic 100/7");
        applyStimulus(16'd100, 16'd7, 1'b0, acc1);
        bad = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clock);
            if (in_ready !== 1'b0) bad++;
        end
        checkOutput("busy_in_ready_low", bad, 0);
        waitDrain("drain_basic");
        repeat (3) @(negedge clock);
        checkOutput("idle_in_ready", 32'(in_ready), 1);
        checkOutput("idle_out_valid", 32'(out_valid), 0);
        checkOutput("held_quotient", 32'(out_quotient), 14);
        checkOutput("held_remainder", 32'(out_remainder), 2);

        // Boundary operands.
        $display("[TB] boundaries");
        bndA[0] = 16'hFFFF; bndB[0] = 16'd1;
        bndA[1] = 16'd3;    bndB[1] = 16'd10;
        bndA[2] = 16'hFFFF; bndB[2] = 16'hFFFF;
        bndA[3] = 16'd0;    bndB[3] = 16'd5;
        for (int i = 0; i < 4; i++) applyStimulus(bndA[i], bndB[i], 1'b0, acc1);
        waitDrain("drain_boundary");

        // Divide by zero, then a normal divide clears the flag.
        $display("[TB] divide by zero");
        applyStimulus(16'd5, 16'd0, 1'b0, acc1);
        waitDrain("drain_dbz");
        checkOutput("dbz_held", 32'(div_by_zero), 1);
        applyStimulus(16'd9, 16'd3, 1'b0, acc1);
        waitDrain("drain_after_dbz");

        // Back-to-back: in_valid held, second operation issued in the DONE cycle.
        $display("[TB] back-to-back");
        applyStimulus(16'd50, 16'd6, 1'b1, acc1);
        applyStimulus(16'd77, 16'd8, 1'b0, acc2);
        checkOutput("b2b_issue_gap", acc2 - acc1, LATENCY);
        waitDrain("drain_b2b");

        // Requests and operand changes while busy must be ignored.
        $display("[TB] ignored input while busy");
        p0 = pulses;
        applyStimulus(16'd1000, 16'd7, 1'b0, acc1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
        in_valid = 1'b0;
        waitDrain("drain_ignored");
        repeat (3) @(negedge clock);
        checkOutput("ignored_pulse_count", pulses - p0, 1);

        // Reset in the middle of an operation discards it.
        $display("[TB] reset mid-operation");
        applyStimulus(16'd1000, 16'd3, 1'b0, acc1);
        repeat (8) @(posedge clock);
        #2;
        reset_n = 1'b0;
        expQ.delete();
        p0 = pulses;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 1);
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_quotient", 32'(out_quotient), 0);
        checkOutput("midrst_remainder", 32'(out_remainder), 0);
        checkOutput("midrst_div_by_zero", 32'(div_by_zero), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("midrst_no_pulse", pulses - p0, 0);
        applyStimulus(16'd1000, 16'd3, 1'b0, acc1);
        waitDrain("drain_after_reset");

        // Randomized traffic, with occasional zero and small divisors.
        $display("[TB] random traffic");
        p0 = pulses;
        nOps = 40;
        for (int i = 0; i < nOps; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            hold = (i != nOps - 1) && ($urandom_range(0, 1) == 1);
            applyStimulus(ra, rb, hold, acc1);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        in_valid = 1'b0;
        waitDrain("drain_random");
        checkOutput("random_pulse_count", pulses - p0, nOps);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
